// File: rtl/tdm_demux_4ch_pkg.sv
// Shared types and defaults for the 4-channel TDM demultiplexer.
package tdm_demux_4ch_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_SLOT_W   = 2;

  // Frame-alignment tracker: HUNT waits for FSYNC, LOCK follows the slot counter.
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_demux_4ch_if.sv
// Serial TDM input and parallel frame output bundle.
interface tdm_demux_4ch_if #(
  parameter int CHANNELS = 4,
  parameter int SLOT_W   = 2
);
  logic                en;
  logic                din;
  logic                fsync;
  logic [CHANNELS-1:0] ch_out;
  logic                frame_valid;
  logic [SLOT_W-1:0]   slot;
  logic                locked;
  logic                sync_err;

  modport master (
    output en, din, fsync,
    input  ch_out, frame_valid, slot, locked, sync_err
  );

  modport slave (
    input  en, din, fsync,
    output ch_out, frame_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux_4ch_mod_counter.sv
// Wrapping slot counter with synchronous clear, load-to-one and increment enable.
module mod_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_reg;

  // Clear beats load-1, which beats increment; natural wrap gives mod 2**W.
  always_ff @(posedge clk) begin
    if (rst || clr)
      count_reg <= '0;
    else if (load1)
      count_reg <= W'(1);
    else if (inc)
      count_reg <= count_reg + W'(1);
  end

  assign count = count_reg;
endmodule

// File: rtl/tdm_demux_4ch.sv
// TDM receive demultiplexer: assembles CHANNELS serial slots into a shadow word and
// publishes complete frames in parallel, tracking FSYNC alignment with HUNT/LOCK.
module tdm_demux_4ch
  import tdm_demux_4ch_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SLOT_W   = DEF_SLOT_W
) (
  input  logic            clk,
  input  logic            rst,
  tdm_demux_4ch_if.slave  bus
);
  state_e              state_reg, state_next;
  logic [CHANNELS-1:0] shadow_reg, shadow_next;
  logic [CHANNELS-1:0] ch_out_reg, ch_out_next;
  logic                frame_valid_reg, frame_valid_next;
  logic                sync_err_reg, sync_err_next;
  logic [SLOT_W-1:0]   slot;
  logic [CHANNELS-1:0] slot_hit;
  logic                cnt_clr, cnt_load1, cnt_inc;
  logic                at_slot0, at_last;

  mod_counter #(.W(SLOT_W)) u_slot_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .count (slot)
  );

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot_dec
    assign slot_hit[gi] = (slot == SLOT_W'(gi));
  end

  assign at_slot0 = slot_hit[0];
  assign at_last  = slot_hit[CHANNELS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_HUNT;
      shadow_reg      <= '0;
      ch_out_reg      <= '0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shadow_reg      <= shadow_next;
      ch_out_reg      <= ch_out_next;
      frame_valid_reg <= frame_valid_next;
      sync_err_reg    <= sync_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    shadow_next      = shadow_reg;
    ch_out_next      = ch_out_reg;
    frame_valid_next = 1'b0;
    sync_err_next    = 1'b0;
    cnt_clr          = 1'b0;
    cnt_load1        = 1'b0;
    cnt_inc          = 1'b0;

    if (bus.en) begin
      case (state_reg)
        ST_HUNT: begin
          if (bus.fsync) begin
            shadow_next[0] = bus.din;
            cnt_load1      = 1'b1;
            state_next     = ST_LOCK;
          end
        end
        default: begin
          if (bus.fsync == at_slot0) begin
            for (int i = 0; i < CHANNELS; i++)
              if (slot_hit[i]) shadow_next[i] = bus.din;
            cnt_inc = 1'b1;
            // The last bit bypasses the shadow so the frame lands in one step.
            if (at_last) begin
              ch_out_next      = {bus.din, shadow_reg[CHANNELS-2:0]};
              frame_valid_next = 1'b1;
            end
          end else if (bus.fsync) begin
            sync_err_next  = 1'b1;
            shadow_next[0] = bus.din;
            cnt_load1      = 1'b1;
          end else begin
            sync_err_next = 1'b1;
            cnt_clr       = 1'b1;
            state_next    = ST_HUNT;
          end
        end
      endcase
    end
  end

  assign bus.ch_out      = ch_out_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.slot        = slot;
  assign bus.locked      = (state_reg == ST_LOCK);
  assign bus.sync_err    = sync_err_reg;
endmodule
